// File: rtl/rob_pkg.sv
// Shared types and defaults for the reorder buffer and its neighbours (PRF, ARAT).
// Width helpers keep tag/pointer derivation in one place.
package rob_pkg;

  localparam int DEF_DEPTH   = 16;
  localparam int DEF_ALLOC_W = 3;
  localparam int DEF_WB_W    = 2;
  localparam int DEF_RET_W   = 3;
  localparam int DEF_PREG_W  = 5;

  function automatic int tag_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra wrap bit lets equal indices mean either empty or full.
  function automatic int ptr_width(input int depth);
    return tag_width(depth) + 1;
  endfunction

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  exp;
    logic [DEF_PREG_W-1:0] pw;
    logic [DEF_PREG_W-1:0] pw_old;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_select.sv
// In-order retire priority chain over the RET_W oldest entries.
// A lane retires only if every older lane retires and none of them excepted.
module rob_retire_select
  import rob_pkg::*;
#(
  parameter  int RET_W = DEF_RET_W,
  localparam int RC_W  = $clog2(RET_W + 1)
) (
  input  logic [RET_W-1:0] head_valid,
  input  logic [RET_W-1:0] head_done,
  input  logic [RET_W-1:0] head_exp,
  output logic [RET_W-1:0] retire_valid,
  output logic [RET_W-1:0] retire_exp,
  output logic [RC_W-1:0]  retire_cnt
);

  logic chain_open;

  always_comb begin
    retire_valid = '0;
    retire_exp   = '0;
    retire_cnt   = '0;
    chain_open   = 1'b1;
    for (int k = 0; k < RET_W; k++) begin
      if (chain_open && head_valid[k] && head_done[k]) begin
        retire_valid[k] = 1'b1;
        retire_exp[k]   = head_exp[k];
        retire_cnt      = retire_cnt + RC_W'(1);
        chain_open      = !head_exp[k];
      end else begin
        chain_open = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multi.sv
// Multi-issue reorder buffer: compacted in-order allocation, out-of-order
// completion, in-order retirement with exception cut-off.
module rob_multi
  import rob_pkg::*;
#(
  parameter  int DEPTH   = DEF_DEPTH,
  parameter  int ALLOC_W = DEF_ALLOC_W,
  parameter  int WB_W    = DEF_WB_W,
  parameter  int RET_W   = DEF_RET_W,
  parameter  int PREG_W  = DEF_PREG_W,
  localparam int TAG_W   = tag_width(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      freeze_front,
  input  logic [ALLOC_W-1:0]        valid_issue,
  input  logic [ALLOC_W*PREG_W-1:0] pw_new,
  input  logic [ALLOC_W*PREG_W-1:0] pw_old,
  output logic [ALLOC_W*TAG_W-1:0]  tag_alloc,
  output logic                      full_ROB,
  output logic                      empty_ROB,
  input  logic [WB_W-1:0]           valid_wb,
  input  logic [WB_W*TAG_W-1:0]     tag_wb,
  input  logic [WB_W-1:0]           exp_wb,
  output logic [RET_W-1:0]          retire_valid,
  output logic [RET_W-1:0]          retire_exp,
  output logic [RET_W*PREG_W-1:0]   retire_pw,
  output logic [RET_W*PREG_W-1:0]   retire_pw_old
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = TAG_W + 1;
  localparam int AC_W  = $clog2(ALLOC_W + 1);
  localparam int RC_W  = $clog2(RET_W + 1);

  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [DEPTH-1:0]  valid_q, done_q, exp_q;
  logic [DEPTH-1:0]  valid_d, done_d, exp_d;
  logic [PREG_W-1:0] pw_q     [DEPTH];
  logic [PREG_W-1:0] pw_old_q [DEPTH];

  logic [TAG_W-1:0]  lane_tag [ALLOC_W];
  logic [AC_W-1:0]   alloc_cnt;
  logic              alloc_en;
  logic [TAG_W-1:0]  ret_idx  [RET_W];
  rob_entry_t        head_ent [RET_W];
  logic [RET_W-1:0]  head_valid, head_done, head_exp;
  logic [RC_W-1:0]   retire_cnt;

  assign full_ROB  = count_q > CNT_W'(DEPTH - ALLOC_W);
  assign empty_ROB = head_q == tail_q;
  assign alloc_en  = !full_ROB && !freeze_front && !flush;

  // Compacted tags: each lane takes tail plus the requesting lanes below it.
  always_comb begin
    logic [TAG_W-1:0] acc;
    acc       = tail_q[TAG_W-1:0];
    alloc_cnt = '0;
    tag_alloc = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      lane_tag[i]                  = acc;
      tag_alloc[i*TAG_W +: TAG_W]  = rst ? acc : TAG_W'(i);
      if (valid_issue[i]) begin
        acc       = acc + TAG_W'(1);
        alloc_cnt = alloc_cnt + AC_W'(1);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < RET_W; k++) begin
      ret_idx[k]  = head_q[TAG_W-1:0] + TAG_W'(k);
      head_ent[k] = '{valid:  valid_q[ret_idx[k]],
                      done:   done_q[ret_idx[k]],
                      exp:    exp_q[ret_idx[k]],
                      pw:     pw_q[ret_idx[k]],
                      pw_old: pw_old_q[ret_idx[k]]};
      head_valid[k]                     = head_ent[k].valid;
      head_done[k]                      = head_ent[k].done;
      head_exp[k]                       = head_ent[k].exp;
      retire_pw[k*PREG_W +: PREG_W]     = head_ent[k].pw;
      retire_pw_old[k*PREG_W +: PREG_W] = head_ent[k].pw_old;
    end
  end

  rob_retire_select #(.RET_W(RET_W)) u_retire_select (
    .head_valid  (head_valid),
    .head_done   (head_done),
    .head_exp    (head_exp),
    .retire_valid(retire_valid),
    .retire_exp  (retire_exp),
    .retire_cnt  (retire_cnt)
  );

  // NOTE: next-state is built with blocking assignments in one comb block so
  // two writeback channels hitting the same tag accumulate exp instead of the
  // last non-blocking write silently winning.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    exp_d   = exp_q;
    for (int c = 0; c < WB_W; c++) begin
      if (valid_wb[c] && valid_q[tag_wb[c*TAG_W +: TAG_W]]) begin
        done_d[tag_wb[c*TAG_W +: TAG_W]] = 1'b1;
        exp_d[tag_wb[c*TAG_W +: TAG_W]]  = exp_d[tag_wb[c*TAG_W +: TAG_W]] | exp_wb[c];
      end
    end
    for (int k = 0; k < RET_W; k++) begin
      if (retire_valid[k]) begin
        valid_d[ret_idx[k]] = 1'b0;
        done_d[ret_idx[k]]  = 1'b0;
        exp_d[ret_idx[k]]   = 1'b0;
      end
    end
    if (alloc_en) begin
      for (int i = 0; i < ALLOC_W; i++) begin
        if (valid_issue[i]) begin
          valid_d[lane_tag[i]] = 1'b1;
          done_d[lane_tag[i]]  = 1'b0;
          exp_d[lane_tag[i]]   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      exp_q   <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      exp_q   <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(retire_cnt);
      tail_q  <= tail_q + (alloc_en ? PTR_W'(alloc_cnt) : '0);
      count_q <= count_q + (alloc_en ? CNT_W'(alloc_cnt) : '0) - CNT_W'(retire_cnt);
      valid_q <= valid_d;
      done_q  <= done_d;
      exp_q   <= exp_d;
    end
  end

  // NOTE: the register payload has no reset; it is only read behind a valid
  // bit, so resetting it would just add reset fan-out to a plain RAM-like array.
  always_ff @(posedge clk) begin
    if (alloc_en) begin
      for (int i = 0; i < ALLOC_W; i++) begin
        if (valid_issue[i]) begin
          pw_q[lane_tag[i]]     <= pw_new[i*PREG_W +: PREG_W];
          pw_old_q[lane_tag[i]] <= pw_old[i*PREG_W +: PREG_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: allocation tags, completion/retire ordering,
// exception cut-off, full back-pressure, wrap-around and async reset.
module tb_rob_multi;

  localparam int DEPTH   = 16;
  localparam int ALLOC_W = 3;
  localparam int WB_W    = 2;
  localparam int RET_W   = 3;
  localparam int PREG_W  = 5;
  localparam int TAG_W   = 4;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      flush = 1'b0;
  logic                      freeze_front = 1'b0;
  logic [ALLOC_W-1:0]        valid_issue = '0;
  logic [ALLOC_W*PREG_W-1:0] pw_new = '0;
  logic [ALLOC_W*PREG_W-1:0] pw_old = '0;
  logic [ALLOC_W*TAG_W-1:0]  tag_alloc;
  logic                      full_ROB, empty_ROB;
  logic [WB_W-1:0]           valid_wb = '0;
  logic [WB_W*TAG_W-1:0]     tag_wb = '0;
  logic [WB_W-1:0]           exp_wb = '0;
  logic [RET_W-1:0]          retire_valid, retire_exp;
  logic [RET_W*PREG_W-1:0]   retire_pw, retire_pw_old;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int retired = 0;

  rob_multi dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .freeze_front (freeze_front),
    .valid_issue  (valid_issue),
    .pw_new       (pw_new),
    .pw_old       (pw_old),
    .tag_alloc    (tag_alloc),
    .full_ROB     (full_ROB),
    .empty_ROB    (empty_ROB),
    .valid_wb     (valid_wb),
    .tag_wb       (tag_wb),
    .exp_wb       (exp_wb),
    .retire_valid (retire_valid),
    .retire_exp   (retire_exp),
    .retire_pw    (retire_pw),
    .retire_pw_old(retire_pw_old)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_issue  = '0;
    pw_new       = '0;
    pw_old       = '0;
    valid_wb     = '0;
    tag_wb       = '0;
    exp_wb       = '0;
    flush        = 1'b0;
    freeze_front = 1'b0;
  endtask

  task automatic alloc(input logic [2:0] vi, input logic [14:0] pn, input logic [14:0] po);
    valid_issue = vi;
    pw_new      = pn;
    pw_old      = po;
  endtask

  task automatic wb(input logic [1:0] v, input logic [7:0] t, input logic [1:0] e);
    valid_wb = v;
    tag_wb   = t;
    exp_wb   = e;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    idle();
  endtask

  // Consume this cycle's retirements against the issue-order scoreboard.
  task automatic sample();
    int n;
    #1;
    for (int k = 0; k < RET_W; k++) begin
      if (retire_valid[k]) begin
        if (exp_q.size() == 0) begin
          check("wrap_extra", 32'(retire_valid[k]), 32'd0);
        end else begin
          n = exp_q.pop_front();
          check("wrap_pw",  32'(retire_pw[k*PREG_W +: PREG_W]),     32'(n % 32));
          check("wrap_old", 32'(retire_pw_old[k*PREG_W +: PREG_W]), 32'((n + 11) % 32));
          retired++;
        end
      end
    end
  endtask

  function automatic logic [14:0] pack_pw(input int a, input int b, input int c);
    logic [4:0] a5, b5, c5;
    a5 = 5'(a % 32);
    b5 = 5'(b % 32);
    c5 = 5'(c % 32);
    return {c5, b5, a5};
  endfunction

  initial begin
    int tail_m;
    int seq;
    logic [3:0] t0, t1, t2;

    // Reset state
    #1 rst = 1'b0;
    #2;
    check("rst_full",  32'(full_ROB),     32'd0);
    check("rst_empty", 32'(empty_ROB),    32'd1);
    check("rst_ret",   32'(retire_valid), 32'd0);
    check("rst_tag",   32'(tag_alloc),    32'({4'd2, 4'd1, 4'd0}));
    @(negedge clk);
    rst = 1'b1;
    step();

    // 1: compacted tags
    alloc(3'b101, {5'd7, 5'd0, 5'd9}, {5'd17, 5'd0, 5'd19});
    #1;
    check("t1_tag", 32'(tag_alloc), 32'({4'd1, 4'd1, 4'd0}));
    step();
    idle();
    #1;
    check("t1_empty", 32'(empty_ROB),      32'd0);
    check("t1_tail",  32'(tag_alloc[3:0]), 32'd2);
    check("t1_full",  32'(full_ROB),       32'd0);
    wb(2'b11, {4'd1, 4'd0}, 2'b00);
    step();
    idle();
    #1;
    check("t1_ret",    32'(retire_valid),        32'b011);
    check("t1_pw",     32'(retire_pw[9:0]),      32'({5'd7, 5'd9}));
    check("t1_pw_old", 32'(retire_pw_old[9:0]),  32'({5'd17, 5'd19}));
    step();
    check("t1_drained", 32'(empty_ROB), 32'd1);
    do_flush();

    // 2: out-of-order completion, in-order retire
    alloc(3'b111, {5'd3, 5'd2, 5'd1}, {5'd13, 5'd12, 5'd11});
    step();
    idle();
    wb(2'b11, {4'd2, 4'd0}, 2'b00);
    step();
    idle();
    #1;
    check("t2_ret0",    32'(retire_valid),          32'b001);
    check("t2_pw0",     32'(retire_pw[4:0]),        32'd1);
    check("t2_pw_old0", 32'(retire_pw_old[4:0]),    32'd11);
    wb(2'b01, {4'd0, 4'd1}, 2'b00);
    step();
    idle();
    #1;
    check("t2_ret12",    32'(retire_valid),         32'b011);
    check("t2_pw12",     32'(retire_pw[9:0]),       32'({5'd3, 5'd2}));
    check("t2_pw_old12", 32'(retire_pw_old[9:0]),   32'({5'd13, 5'd12}));
    step();
    check("t2_empty", 32'(empty_ROB), 32'd1);
    do_flush();

    // 3: exception cut-off, then flush
    alloc(3'b111, {5'd6, 5'd5, 5'd4}, {5'd16, 5'd15, 5'd14});
    step();
    idle();
    wb(2'b11, {4'd2, 4'd1}, 2'b01);
    step();
    idle();
    #1;
    check("t3_hold", 32'(retire_valid), 32'b000);
    wb(2'b01, {4'd0, 4'd0}, 2'b00);
    step();
    idle();
    #1;
    check("t3_ret", 32'(retire_valid), 32'b011);
    check("t3_exp", 32'(retire_exp),   32'b010);
    flush = 1'b1;
    #1;
    check("t3_ret_in_flush", 32'(retire_valid), 32'b011);
    step();
    idle();
    valid_issue = 3'b111;
    #1;
    check("t3_empty", 32'(empty_ROB),    32'd1);
    check("t3_ptrs",  32'(tag_alloc),    32'({4'd2, 4'd1, 4'd0}));
    check("t3_ret_cleared", 32'(retire_valid), 32'd0);
    idle();

    // freeze_front drops requests
    freeze_front = 1'b1;
    alloc(3'b111, 15'h7fff, 15'h7fff);
    step();
    idle();
    #1;
    check("frz_tail",  32'(tag_alloc[3:0]), 32'd0);
    check("frz_empty", 32'(empty_ROB),      32'd1);

    // 4: full back-pressure at count 14
    for (int j = 0; j < 4; j++) begin
      alloc(3'b111, pack_pw(3*j, 3*j+1, 3*j+2), pack_pw(3*j, 3*j+1, 3*j+2));
      step();
    end
    alloc(3'b011, pack_pw(12, 13, 0), pack_pw(12, 13, 0));
    step();
    idle();
    #1;
    check("t4_full",  32'(full_ROB),       32'd1);
    check("t4_tail",  32'(tag_alloc[3:0]), 32'd14);
    alloc(3'b111, 15'h7fff, 15'h7fff);
    step();
    idle();
    #1;
    check("t4_drop", 32'(tag_alloc[3:0]), 32'd14);
    wb(2'b01, {4'd0, 4'd0}, 2'b00);
    step();
    idle();
    #1;
    check("t4_ret1", 32'(retire_valid), 32'b001);
    step();
    check("t4_not_full", 32'(full_ROB), 32'd0);
    alloc(3'b111, 15'd0, 15'd0);
    #1;
    check("t4_wrap_tags", 32'(tag_alloc), 32'({4'd0, 4'd15, 4'd14}));
    step();
    idle();
    #1;
    check("t4_full_again", 32'(full_ROB), 32'd1);
    do_flush();

    // 5: wrap-around stream, scoreboard on retire order
    tail_m = 0;
    seq    = 0;
    for (int it = 0; it < 40; it++) begin
      t0 = 4'(tail_m % DEPTH);
      t1 = 4'((tail_m + 1) % DEPTH);
      t2 = 4'((tail_m + 2) % DEPTH);
      alloc(3'b111, pack_pw(seq, seq+1, seq+2), pack_pw(seq+11, seq+12, seq+13));
      #1;
      check("wrap_tag", 32'(tag_alloc), 32'({t2, t1, t0}));
      for (int i = 0; i < 3; i++) exp_q.push_back(seq + i);
      sample();
      step();
      idle();
      wb(2'b11, {t1, t0}, 2'b00);
      sample();
      step();
      idle();
      wb(2'b01, {4'd0, t2}, 2'b00);
      sample();
      step();
      idle();
      tail_m += 3;
      seq    += 3;
    end
    repeat (3) begin
      sample();
      step();
    end
    check("wrap_total",  32'(retired),      32'd120);
    check("wrap_left",   32'(exp_q.size()), 32'd0);
    check("wrap_empty",  32'(empty_ROB),    32'd1);
    do_flush();

    // 6: async reset mid-stream with count 7
    alloc(3'b111, 15'd0, 15'd0);
    step();
    step();
    alloc(3'b001, 15'd0, 15'd0);
    step();
    idle();
    wb(2'b11, {4'd1, 4'd0}, 2'b00);
    step();
    idle();
    #2;
    check("t6_pre_ret",   32'(retire_valid),   32'b011);
    check("t6_pre_tail",  32'(tag_alloc[3:0]), 32'd7);
    rst = 1'b0;
    #1;
    check("t6_full",  32'(full_ROB),     32'd0);
    check("t6_empty", 32'(empty_ROB),    32'd1);
    check("t6_ret",   32'(retire_valid), 32'd0);
    check("t6_tag",   32'(tag_alloc),    32'({4'd2, 4'd1, 4'd0}));
    #2;
    rst = 1'b1;
    step();
    check("t6_after", 32'(empty_ROB), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
